// File: rtl/uart_cmd_link.sv
// Full-duplex 8N1 UART command link: assembles CMD_BYTES received bytes into a command word and serialises a RESP_BYTES response.
// Optional trailing XOR checksum byte on receive is enabled by defining UART_CMD_CHECKSUM_EN.
module uart_cmd_link #(
  parameter int CMD_BYTES    = 3,
  parameter int RESP_BYTES   = 1,
  parameter int BAUD_DIV     = 2604,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    RX,
  output logic                    TX,
  input  logic                    clr_cmd_rdy,
  output logic [8*CMD_BYTES-1:0]  cmd,
  output logic                    cmd_rdy,
  output logic                    cmd_ovr,
  output logic                    cmd_err,
  input  logic [8*RESP_BYTES-1:0] resp_data,
  input  logic                    send_resp,
  output logic                    resp_busy,
  output logic                    resp_done
);

  localparam int CMD_W    = 8 * CMD_BYTES;
  localparam int RESP_W   = 8 * RESP_BYTES;
`ifdef UART_CMD_CHECKSUM_EN
  localparam int FRAME_BYTES = CMD_BYTES + 1;
`else
  localparam int FRAME_BYTES = CMD_BYTES;
`endif
  localparam int HALF     = BAUD_DIV / 2;
  localparam int TO_LIMIT = TIMEOUT_BITS * BAUD_DIV;
  localparam int BW       = $clog2(BAUD_DIV + 1);
  localparam int TW       = $clog2(TO_LIMIT + 1);
  localparam int CW       = $clog2(FRAME_BYTES + 1);
  localparam int IW       = $clog2(RESP_BYTES + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

  // ---------------- receive side ----------------
  logic              rx_meta, rx_sync, rx_prev, rx_fall;
  uart_state_e       rx_state, rx_next;
  logic [BW-1:0]     rx_baud;
  logic [2:0]        rx_bit;
  logic [7:0]        rx_shift;
  logic [CW-1:0]     byte_cnt;
  logic [CMD_W-1:0]  hold;
  logic [TW-1:0]     idle_cnt;
  logic              complete;
  logic              rx_half_end, rx_bit_end, stop_sample, stop_ok, stop_bad;
  logic              accept_data, finish, rx_err, partial, timeout;

  // Preset to 1 so reset release never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make each flop sample the previous stage's old value.
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall     = rx_prev & ~rx_sync;
  assign rx_half_end = (rx_baud == BW'(HALF - 1));
  assign rx_bit_end  = (rx_baud == BW'(BAUD_DIV - 1));
  assign stop_sample = (rx_state == S_STOP) && rx_bit_end;
  assign stop_ok     = stop_sample & rx_sync;
  assign stop_bad    = stop_sample & ~rx_sync;
  assign accept_data = stop_ok && (byte_cnt < CW'(CMD_BYTES));

`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0] hold_xor;
  logic       chk_byte, chk_match;

  always_comb begin
    hold_xor = '0;
    for (int i = 0; i < CMD_BYTES; i++) hold_xor ^= hold[8*i +: 8];
  end

  assign chk_byte  = stop_ok && (byte_cnt == CW'(CMD_BYTES));
  assign chk_match = (rx_shift == hold_xor);
  assign finish    = chk_byte & chk_match;
  assign rx_err    = stop_bad | (chk_byte & ~chk_match);
`else
  assign finish    = accept_data && (byte_cnt == CW'(CMD_BYTES - 1));
  assign rx_err    = stop_bad;
`endif

  assign partial = (byte_cnt != '0) && (byte_cnt < CW'(FRAME_BYTES));
  assign timeout = (rx_state == S_IDLE) && partial && (idle_cnt == TW'(TO_LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state <= S_IDLE;
    else     rx_state <= rx_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns rx_next and no latch is inferred.
    rx_next = rx_state;
    case (rx_state)
      S_IDLE:  if (rx_fall) rx_next = S_START;
      S_START: if (rx_half_end) rx_next = rx_sync ? S_IDLE : S_DATA;
      S_DATA:  if (rx_bit_end && rx_bit == 3'd7) rx_next = S_STOP;
      S_STOP:  if (rx_bit_end) rx_next = S_IDLE;
      default: rx_next = S_IDLE;
    endcase
  end

  // NOTE: the holding register is a handful of flops, so it is reset like everything else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_baud  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      byte_cnt <= '0;
      hold     <= '0;
      idle_cnt <= '0;
      complete <= 1'b0;
      cmd      <= '0;
      cmd_rdy  <= 1'b0;
      cmd_ovr  <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      if (rx_state == S_IDLE || (rx_state == S_START ? rx_half_end : rx_bit_end))
        rx_baud <= '0;
      else
        rx_baud <= rx_baud + BW'(1);

      if (rx_state == S_START)
        rx_bit <= '0;
      else if (rx_state == S_DATA && rx_bit_end)
        rx_bit <= rx_bit + 3'd1;

      if (rx_state == S_DATA && rx_bit_end)
        rx_shift <= {rx_sync, rx_shift[7:1]};

      if (accept_data)
        hold <= (hold << 8) | CMD_W'(rx_shift);

      if (complete || rx_err || timeout)
        byte_cnt <= '0;
      else if (accept_data)
        byte_cnt <= byte_cnt + CW'(1);

      if (rx_state != S_IDLE || !partial || rx_fall || timeout)
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + TW'(1);

      complete <= finish;
      cmd_err  <= rx_err;

      // A completion outranks a simultaneous clear; overrun only counts an unacknowledged command.
      if (complete) begin
        cmd     <= hold;
        cmd_rdy <= 1'b1;
        cmd_ovr <= clr_cmd_rdy ? 1'b0 : (cmd_ovr | cmd_rdy);
      end else if (clr_cmd_rdy) begin
        cmd_rdy <= 1'b0;
        cmd_ovr <= 1'b0;
      end
    end
  end

  // ---------------- transmit side ----------------
  uart_state_e       tx_state, tx_next;
  logic [BW-1:0]     tx_baud;
  logic [2:0]        tx_bit;
  logic [IW-1:0]     tx_idx;
  logic [7:0]        byte_sh;
  logic [RESP_W-1:0] resp_sh;
  logic              tx_bit_end, tx_last;

  assign tx_bit_end = (tx_baud == BW'(BAUD_DIV - 1));
  assign tx_last    = (tx_idx == IW'(RESP_BYTES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_state <= S_IDLE;
    else     tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      S_IDLE:  if (send_resp) tx_next = S_START;
      S_START: if (tx_bit_end) tx_next = S_DATA;
      S_DATA:  if (tx_bit_end && tx_bit == 3'd7) tx_next = S_STOP;
      S_STOP:  if (tx_bit_end) tx_next = tx_last ? S_IDLE : S_START;
      default: tx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_baud   <= '0;
      tx_bit    <= '0;
      tx_idx    <= '0;
      byte_sh   <= '0;
      resp_sh   <= '0;
      TX        <= 1'b1;
      resp_busy <= 1'b0;
      resp_done <= 1'b0;
    end else begin
      resp_done <= 1'b0;
      if (tx_state == S_IDLE || tx_bit_end) tx_baud <= '0;
      else                                  tx_baud <= tx_baud + BW'(1);

      case (tx_state)
        S_IDLE: if (send_resp) begin
          byte_sh   <= resp_data[RESP_W-1 -: 8];
          resp_sh   <= resp_data << 8;
          tx_idx    <= '0;
          TX        <= 1'b0;
          resp_busy <= 1'b1;
        end
        S_START: if (tx_bit_end) begin
          TX      <= byte_sh[0];
          byte_sh <= byte_sh >> 1;
          tx_bit  <= '0;
        end
        S_DATA: if (tx_bit_end) begin
          if (tx_bit == 3'd7) begin
            TX <= 1'b1;
          end else begin
            TX      <= byte_sh[0];
            byte_sh <= byte_sh >> 1;
            tx_bit  <= tx_bit + 3'd1;
          end
        end
        S_STOP: if (tx_bit_end) begin
          if (tx_last) begin
            resp_busy <= 1'b0;
            resp_done <= 1'b1;
          end else begin
            TX      <= 1'b0;
            byte_sh <= resp_sh[RESP_W-1 -: 8];
            resp_sh <= resp_sh << 8;
            tx_idx  <= tx_idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_link.sv
// Self-checking bench for uart_cmd_link: directed scenarios plus randomized commands scored against a byte-queue model.
// Build with UART_CMD_CHECKSUM_EN defined to exercise the checksum variant.
module tb_uart_cmd_link;

  localparam int BAUD = 16;
  localparam int TOB  = 20;
`ifdef UART_CMD_CHECKSUM_EN
  localparam int FRAME = 4;
`else
  localparam int FRAME = 3;
`endif
  localparam int LAT = FRAME * 10 * BAUD;

  logic              clk, rst, tx, rx_line, rx_drv, loopback;
  logic              clr_cmd_rdy, cmd_rdy, cmd_ovr, cmd_err;
  logic [23:0]       cmd;
  logic [8*FRAME-1:0] resp_data;
  logic              send_resp, resp_busy, resp_done;

  int checks = 0;
  int errors = 0;

  uart_cmd_link #(.CMD_BYTES(3), .RESP_BYTES(FRAME), .BAUD_DIV(BAUD), .TIMEOUT_BITS(TOB)) dut (
    .clk(clk), .rst(rst), .RX(rx_line), .TX(tx), .clr_cmd_rdy(clr_cmd_rdy),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .cmd_ovr(cmd_ovr), .cmd_err(cmd_err),
    .resp_data(resp_data), .send_resp(send_resp), .resp_busy(resp_busy), .resp_done(resp_done)
  );

  assign rx_line = loopback ? tx : rx_drv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitors: cycles with cmd_err high, and whether the stale 0x112233 command ever appears.
  int err_cycles = 0;
  bit watch_bad = 0;
  bit bad_seen = 0;
  always @(negedge clk) begin
    if (cmd_err === 1'b1) err_cycles++;
    if (watch_bad && cmd === 24'h112233) bad_seen = 1;
  end

  // Reference model: bytes accepted since the last command boundary.
  logic [7:0]  mq[$];
  logic [23:0] exp_cmd = '0;
  int          exp_err = 0;

  task automatic model_byte(input logic [7:0] b);
    mq.push_back(b);
    if (mq.size() == FRAME) begin
`ifdef UART_CMD_CHECKSUM_EN
      if (mq[3] == (mq[0] ^ mq[1] ^ mq[2])) exp_cmd = {mq[0], mq[1], mq[2]};
      else exp_err++;
`else
      exp_cmd = {mq[0], mq[1], mq[2]};
`endif
      mq.delete();
    end
  endtask

  function automatic logic [8*FRAME-1:0] make_resp(input logic [23:0] c);
`ifdef UART_CMD_CHECKSUM_EN
    return {c, c[23:16] ^ c[15:8] ^ c[7:0]};
`else
    return c;
`endif
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx_drv = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (BAUD) @(negedge clk);
    end
    rx_drv = stop;
    repeat (BAUD) @(negedge clk);
    rx_drv = 1'b1;
    if (stop) model_byte(b);
    else begin exp_err++; mq.delete(); end
  endtask

  task automatic idle(input int n);
    rx_drv = 1'b1;
    repeat (n) @(negedge clk);
    if (n > TOB * BAUD) mq.delete();
  endtask

  task automatic send_cmd_direct(input logic [23:0] c, input int gap);
    logic [8*FRAME-1:0] w;
    w = make_resp(c);
    for (int i = FRAME - 1; i >= 0; i--) begin
      send_byte(w[8*i +: 8], 1'b1);
      if (i > 0) idle(gap);
    end
  endtask

  // Loopback: the response word returns through RX; lat = cycles from acceptance to resp_done.
  task automatic loop_send(input logic [23:0] c, output int lat);
    logic [8*FRAME-1:0] w;
    w = make_resp(c);
    loopback = 1'b1;
    resp_data = w;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    lat = 0;
    while (resp_done !== 1'b1 && lat < 4000) begin @(negedge clk); lat++; end
    repeat (4) @(negedge clk);
    loopback = 1'b0;
    for (int i = FRAME - 1; i >= 0; i--) model_byte(w[8*i +: 8]);
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    checks++; if (cmd !== 24'h0) begin errors++; $display("FAIL reset_cmd: got %h expected 000000", cmd); end
    checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL reset_cmd_rdy: got %b expected 0", cmd_rdy); end
    checks++; if (cmd_ovr !== 1'b0) begin errors++; $display("FAIL reset_cmd_ovr: got %b expected 0", cmd_ovr); end
    checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL reset_cmd_err: got %b expected 0", cmd_err); end
    checks++; if (resp_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", resp_busy); end
    checks++; if (resp_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", resp_done); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_loopback();
    int lat, e0;
    e0 = err_cycles;
    loop_send(24'h55AAE3, lat);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL loop_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (cmd !== 24'h55AAE3) begin errors++; $display("FAIL loop_cmd: got %h expected 55aae3", cmd); end
    checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL loop_cmd_rdy: got %b expected 1", cmd_rdy); end
    checks++; if (err_cycles !== e0) begin errors++; $display("FAIL loop_cmd_err: got %0d pulses expected 0", err_cycles - e0); end
    checks++; if (resp_busy !== 1'b0) begin errors++; $display("FAIL loop_busy_end: got %b expected 0", resp_busy); end
  endtask

  task automatic test_clear_overrun();
    int lat;
    pulse_clr();
    checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL clr_rdy: got %b expected 0", cmd_rdy); end
    checks++; if (cmd !== 24'h55AAE3) begin errors++; $display("FAIL clr_cmd_hold: got %h expected 55aae3", cmd); end
    loop_send(24'h123456, lat);
    checks++; if (cmd_ovr !== 1'b0) begin errors++; $display("FAIL ovr_first: got %b expected 0", cmd_ovr); end
    loop_send(24'hA5A5A5, lat);
    checks++; if (cmd_ovr !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", cmd_ovr); end
    checks++; if (cmd !== 24'hA5A5A5) begin errors++; $display("FAIL ovr_cmd: got %h expected a5a5a5", cmd); end
    checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL ovr_rdy: got %b expected 1", cmd_rdy); end
    pulse_clr();
    checks++; if (cmd_ovr !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", cmd_ovr); end
  endtask

  task automatic test_busy_ignore();
    logic [23:0] c;
    int lat, stray;
    c = 24'($urandom);
    loopback = 1'b1;
    resp_data = make_resp(c);
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    lat = 0;
    while (resp_done !== 1'b1 && lat < 4000) begin
      @(negedge clk);
      lat++;
      if (lat == 100) begin resp_data = ~resp_data; send_resp = 1'b1; end
      if (lat == 101) send_resp = 1'b0;
    end
    stray = 0;
    repeat (200) begin
      @(negedge clk);
      if (resp_busy !== 1'b0 || tx !== 1'b1) stray++;
    end
    loopback = 1'b0;
    for (int i = FRAME - 1; i >= 0; i--) model_byte(make_resp(c) >> (8 * i));
    checks++; if (lat !== LAT) begin errors++; $display("FAIL busy_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (stray !== 0) begin errors++; $display("FAIL busy_extra_frame: got %0d active cycles expected 0", stray); end
    checks++; if (cmd !== c) begin errors++; $display("FAIL busy_cmd: got %h expected %h", cmd, c); end
  endtask

  task automatic test_timeout();
    pulse_clr();
    watch_bad = 1;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    idle(TOB * BAUD + 1);
    send_cmd_direct(24'h334455, 0);
    repeat (4) @(negedge clk);
    watch_bad = 0;
    checks++; if (cmd !== 24'h334455) begin errors++; $display("FAIL timeout_cmd: got %h expected 334455", cmd); end
    checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL timeout_rdy: got %b expected 1", cmd_rdy); end
    checks++; if (bad_seen !== 1'b0) begin errors++; $display("FAIL timeout_stale: got %b expected 0", bad_seen); end
  endtask

  task automatic test_framing();
    int e0;
    logic [23:0] c;
    pulse_clr();
    e0 = err_cycles;
    send_byte(8'h77, 1'b1);
    send_byte(8'hC3, 1'b0);
    idle(2 * BAUD);
    checks++; if (err_cycles - e0 !== 1) begin errors++; $display("FAIL frame_err_pulse: got %0d cycles expected 1", err_cycles - e0); end
    c = 24'($urandom);
    send_cmd_direct(c, 0);
    repeat (4) @(negedge clk);
    checks++; if (cmd !== c) begin errors++; $display("FAIL frame_recover_cmd: got %h expected %h", cmd, c); end
    checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL frame_recover_rdy: got %b expected 1", cmd_rdy); end
  endtask

  task automatic test_reset_mid_tx();
    logic [23:0] c;
    int lat;
    c = 24'($urandom);
    loopback = 1'b0;
    resp_data = make_resp(c);
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    // Middle of data bit 4 of the second byte.
    repeat (247) @(negedge clk);
    checks++; if (tx !== c[12]) begin errors++; $display("FAIL mid_tx_bit: got %b expected %b", tx, c[12]); end
    checks++; if (resp_busy !== 1'b1) begin errors++; $display("FAIL mid_tx_busy: got %b expected 1", resp_busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_tx: got %b expected 1", tx); end
    checks++; if (resp_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", resp_busy); end
    checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL rst_rdy: got %b expected 0", cmd_rdy); end
    checks++; if (cmd !== 24'h0) begin errors++; $display("FAIL rst_cmd: got %h expected 000000", cmd); end
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    exp_cmd = '0;
    repeat (3) @(negedge clk);
    c = 24'($urandom);
    loop_send(c, lat);
    checks++; if (cmd !== c) begin errors++; $display("FAIL rst_recover_cmd: got %h expected %h", cmd, c); end
  endtask

`ifdef UART_CMD_CHECKSUM_EN
  task automatic test_checksum();
    int e0;
    pulse_clr();
    send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h04, 1'b1); send_byte(8'h07, 1'b1);
    repeat (4) @(negedge clk);
    checks++; if (cmd !== 24'h010204) begin errors++; $display("FAIL chk_cmd: got %h expected 010204", cmd); end
    checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL chk_rdy: got %b expected 1", cmd_rdy); end
    pulse_clr();
    e0 = err_cycles;
    send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h04, 1'b1); send_byte(8'h00, 1'b1);
    repeat (4) @(negedge clk);
    checks++; if (err_cycles - e0 !== 1) begin errors++; $display("FAIL chk_err_pulse: got %0d cycles expected 1", err_cycles - e0); end
    checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL chk_bad_rdy: got %b expected 0", cmd_rdy); end
  endtask
`endif

  task automatic test_random();
    logic [23:0] c;
    int lat, mode, k;
    for (int it = 0; it < 8; it++) begin
      pulse_clr();
      c = 24'($urandom);
      mode = $urandom_range(0, 3);
      case (mode)
        0: begin
          loop_send(c, lat);
          checks++; if (lat !== LAT) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", it, lat, LAT); end
        end
        1: send_cmd_direct(c, $urandom_range(0, 200));
        2: begin
          k = $urandom_range(1, FRAME - 1);
          for (int j = 0; j < k; j++) send_byte(8'($urandom), 1'b1);
          idle(TOB * BAUD + 20);
          send_cmd_direct(c, $urandom_range(0, 200));
        end
        default: begin
          send_byte(8'($urandom), 1'b1);
          send_byte(8'($urandom), 1'b0);
          idle(2 * BAUD);
          send_cmd_direct(c, $urandom_range(0, 200));
        end
      endcase
      repeat (4) @(negedge clk);
      checks++; if (cmd !== exp_cmd) begin errors++; $display("FAIL rand_cmd[%0d] mode %0d: got %h expected %h", it, mode, cmd, exp_cmd); end
      checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL rand_rdy[%0d]: got %b expected 1", it, cmd_rdy); end
      checks++; if (err_cycles !== exp_err) begin errors++; $display("FAIL rand_err_count[%0d]: got %0d expected %0d", it, err_cycles, exp_err); end
    end
  endtask

  initial begin
    rst = 1'b1; rx_drv = 1'b1; loopback = 1'b0;
    clr_cmd_rdy = 1'b0; send_resp = 1'b0; resp_data = '0;
    @(negedge clk);
    test_reset();
    test_loopback();
    test_clear_overrun();
    test_busy_ignore();
    test_timeout();
    test_framing();
    test_reset_mid_tx();
`ifdef UART_CMD_CHECKSUM_EN
    test_checksum();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_cmd_link.md
Name: uart_cmd_link

Overview:
- Parametrised successor to the fixed 3-byte UART command interface: full-duplex 8N1 UART link.
- Receive side assembles CMD_BYTES serial bytes into one command word with a ready/clear handshake.
- Transmit side serialises a RESP_BYTES-wide response word on one request.
- Adds an inter-byte timeout resync and overrun detection. Sits between the host serial pins and the command-processing FSM.

Parameters:
- CMD_BYTES, 3, bytes per command; first byte received lands in the MSB byte of cmd.
- RESP_BYTES, 1, bytes per response; MSB byte transmitted first.
- BAUD_DIV, 2604, clk cycles per bit time (50 MHz / 19200).
- TIMEOUT_BITS, 20, idle bit times allowed between bytes of one command before the partial command is discarded.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- RX  in  1  serial input, asynchronous to clk
- TX  out  1  serial output, idle high
- clr_cmd_rdy  in  1  clears cmd_rdy and cmd_ovr
- cmd  out  8*CMD_BYTES  assembled command
- cmd_rdy  out  1  command valid, level
- cmd_ovr  out  1  sticky: a command completed while cmd_rdy was already set
- cmd_err  out  1  one-cycle pulse on framing error (or checksum error, see option)
- resp_data  in  8*RESP_BYTES  response word, sampled when send_resp is accepted
- send_resp  in  1  start-response strobe
- resp_busy  out  1  transmitter active
- resp_done  out  1  one-cycle pulse after the final stop bit

Behaviour:
- Reset (async, immediate): TX=1, cmd=0, cmd_rdy=0, cmd_ovr=0, cmd_err=0, resp_busy=0, resp_done=0. All counters zero, both FSMs IDLE.
- RX synchronisation: RX passes through a 2-flop synchroniser preset to 1 on reset. Start is detected on a synchronised 1->0 edge.
- RX FSM states:
  - IDLE -> START on falling edge.
  - START: wait BAUD_DIV/2 (integer divide); if the line is 1, treat as a glitch and return to IDLE; else -> DATA.
  - DATA: sample 8 bits LSB first, one sample every BAUD_DIV cycles.
  - STOP: sample after BAUD_DIV. If 1, the byte is accepted. If 0, pulse cmd_err, discard the byte and the partial command, go to IDLE.
- Assembly: a byte counter 0..CMD_BYTES-1 shifts each accepted byte into a holding register, left shift with new byte in the LSBs.
- On the byte that makes the count CMD_BYTES, in the cycle after the stop sample:
  - cmd <= holding register; cmd_rdy <= 1; counter <= 0.
  - If cmd_rdy was already 1, set cmd_ovr. cmd is still overwritten with the newest command.
- cmd holds its value until the next completed command, not cleared by clr_cmd_rdy.
- clr_cmd_rdy clears cmd_rdy and cmd_ovr on the next edge. If clr coincides with a completion edge, the completion wins: cmd_rdy=1 and cmd_ovr is not set.
- Timeout: an idle counter runs in RX IDLE whenever 0 < byte count < CMD_BYTES.
  - It resets at each start edge.
  - Reaching TIMEOUT_BITS*BAUD_DIV cycles zeroes the byte count. No cmd_err pulse, cmd unchanged.
- TX FSM states: IDLE -> START -> DATA (8 bits, LSB first) -> STOP -> next byte or DONE. One bit time is BAUD_DIV cycles.
  - send_resp is accepted in IDLE only; it latches resp_data and sets resp_busy on the next edge.
  - Bytes go out back-to-back with no extra idle bits.
  - After the final stop bit: resp_busy=0 and resp_done pulses 1 cycle in the same edge. A new send_resp is accepted on the following cycle.
  - send_resp while busy is ignored.
- Reset mid-frame: both FSMs abort immediately, TX returns high, the partial command is lost.
- RX and TX are fully independent; loopback (RX tied to TX) is legal.

Optional Feature:
- Macro: UART_CMD_CHECKSUM_EN.
- Defined: the receiver expects one extra byte after the CMD_BYTES data bytes, equal to the XOR of all command bytes.
  - Match: complete the command as above.
  - Mismatch: pulse cmd_err, leave cmd and cmd_rdy unchanged, zero the byte count.
  - The timeout also covers the gap before the checksum byte.
- Undefined: no checksum byte is expected, and cmd_err reports framing errors only.

Test Plan:
- BAUD_DIV=16, CMD_BYTES=3, loopback RX=TX, RESP_BYTES=3, resp_data=24'h55AAE3, pulse send_resp -> resp_done after exactly 3*10*16=480 cycles, cmd=24'h55AAE3, cmd_rdy=1, cmd_err=0.
- After the above, pulse clr_cmd_rdy 1 cycle -> cmd_rdy=0 next cycle, cmd still 24'h55AAE3. Send a second command 24'h123456 without clearing, then a third 24'hA5A5A5 -> cmd_ovr=1, cmd=24'hA5A5A5.
- Drive bytes 0x11, 0x22, then idle 20*16+1 cycles, then 0x33, 0x44, 0x55 -> cmd=24'h334455, never 24'h112233.
- Drive a byte with stop bit 0 -> cmd_err single-cycle pulse, byte count reset; a following valid 3-byte command is received correctly.
- Assert rst mid-transmission (byte 2, bit 4) -> TX=1 and resp_busy=0 combinationally; cmd_rdy=0. Pulse send_resp while busy -> no effect; transmission count stays 3 bytes.
- With UART_CMD_CHECKSUM_EN: send 0x01, 0x02, 0x04, 0x07 -> cmd=24'h010204, cmd_rdy=1. Send 0x01, 0x02, 0x04, 0x00 -> cmd_err pulse, cmd_rdy=0.
